// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: trace capture of debug-bus samples with pre-trigger history and oldest-first readout
module debug_trace_buffer #(
   parameter int DATA_W    = 16,
   parameter int CHANNELS  = 4,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int TRIG_CH   = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         smp_valid,
   input  logic [CHANNELS*DATA_W-1:0]   smp_data,
   input  logic [DATA_W-1:0]            trig_value,
   input  logic [DATA_W-1:0]            trig_mask,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic [CHANNELS*DATA_W-1:0]   rd_data,
   output logic                         rd_last,
   output logic [1:0]                   state,
   output logic [$clog2(DEPTH):0]       count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CHANNELS * DATA_W;

   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d, post_q, post_d, rem_q, rem_d;
   logic            we, hit;
   logic [SW-1:0]   mem [DEPTH];

   assign hit      = smp_valid & (((smp_data[TRIG_CH*DATA_W +: DATA_W] ^ trig_value) & trig_mask) == '0);
   assign rd_valid = (state_q == DONE);
   assign rd_last  = rd_valid & (rem_q == CW'(1));
   assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
   assign state    = state_q;
   assign count    = count_q;

   // next-state: capture until trigger + post window, then drain; abort overrides everything
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      post_d   = post_q;
      rem_d    = rem_q;
      we       = 1'b0;
      case (state_q)
         IDLE: if (arm) begin
            state_d  = ARMED;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            post_d   = '0;
         end
         ARMED, POST: if (smp_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
            if (state_q == ARMED) begin
               if (hit) begin
                  state_d = (POST_TRIG > 0) ? POST : DONE;
                  post_d  = CW'(POST_TRIG);
               end
            end else begin
               post_d = post_q - CW'(1);
               if (post_q == CW'(1)) state_d = DONE;
            end
         end
         DONE: if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rem_d    = rem_q - CW'(1);
            if (rem_q == CW'(1)) state_d = IDLE;
         end
         default: ;
      endcase
      // the oldest held entry sits count places behind the write pointer (count==DEPTH wraps to itself)
      if (state_d == DONE && state_q != DONE) begin
         rd_ptr_d = wr_ptr_d - count_d[PW-1:0];
         rem_d    = count_d;
      end
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
         we      = 1'b0;
      end
   end

   // control registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         post_q   <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         post_q   <= post_d;
         rem_q    <= rem_d;
      end
   end

   // sample storage, contents need no reset
   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= smp_data;
   end
endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed checks of capture, wrap, backpressure, mask, reset and abort
module tb_debug_trace_buffer;
   logic        clk = 1'b0;
   logic        reset, arm, abort, smp_valid, rd_ready;
   logic [63:0] smp_data;
   logic [15:0] trig_value, trig_mask;
   logic        rd_valid, rd_last;
   logic [63:0] rd_data;
   logic [1:0]  state;
   logic [3:0]  count;
   int          vectors = 0;
   int          errors  = 0;

   debug_trace_buffer #(.DATA_W(16), .CHANNELS(4), .DEPTH(8), .POST_TRIG(2), .TRIG_CH(0)) dut (
      .clk(clk), .reset(reset), .arm(arm), .abort(abort), .smp_valid(smp_valid),
      .smp_data(smp_data), .trig_value(trig_value), .trig_mask(trig_mask),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .state(state), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk(input int pc);
      logic [15:0] p;
      p = pc[15:0];
      return {p ^ 16'hA5A5, p + 16'h0100, ~p, p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int tv, input int n);
      trig_value = tv[15:0];
      trig_mask  = 16'hFFFF;
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("armed", 64'(state), 64'd1);
      for (int pc = 0; pc < n; pc++) begin
         smp_valid = 1'b1;
         smp_data  = mk(pc);
         step();
      end
      smp_valid = 1'b0;
   endtask

   task automatic readout(input int first, input int n, input bit bp);
      int idx = 0;
      for (int c = 0; c < 64 && idx < n; c++) begin
         rd_ready = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
         chk("rd_valid", 64'(rd_valid), 64'd1);
         chk("rd_data", rd_data, mk(first + idx));
         chk("rd_last", 64'(rd_last), 64'(idx == n - 1));
         step();
         if (rd_ready) idx++;
      end
      rd_ready = 1'b0;
      chk("xfers", 64'(idx), 64'(n));
      chk("idle_after_read", 64'(state), 64'd0);
      chk("rd_valid_after_read", 64'(rd_valid), 64'd0);
   endtask

   initial begin
      reset = 1'b0; arm = 1'b0; abort = 1'b0; smp_valid = 1'b0; rd_ready = 1'b0;
      smp_data = '0; trig_value = '0; trig_mask = '0;
      #2;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_last", 64'(rd_last), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      #10 reset = 1'b1;
      step();
      // 1: wrap, trigger on PC 10, window 5..12
      capture(10, 20);
      chk("s1_state", 64'(state), 64'd3);
      chk("s1_count", 64'(count), 64'd8);
      readout(5, 8, 1'b0);
      chk("s1_count_held", 64'(count), 64'd8);
      // 2: early trigger, only 5 entries
      capture(2, 10);
      chk("s2_state", 64'(state), 64'd3);
      chk("s2_count", 64'(count), 64'd5);
      readout(0, 5, 1'b0);
      // 3: backpressure
      capture(10, 20);
      chk("s3_count", 64'(count), 64'd8);
      readout(5, 8, 1'b1);
      // 4: mask all-zero and gaps in smp_valid
      trig_mask = 16'h0000;
      trig_value = 16'h1234;
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int i = 0; i < 4; i++) begin
         smp_valid = (i != 1);
         smp_data  = mk(40 + i);
         step();
      end
      smp_valid = 1'b0;
      chk("s4_state", 64'(state), 64'd3);
      chk("s4_count", 64'(count), 64'd3);
      chk("s4_rd0", rd_data, mk(40));
      rd_ready = 1'b1;
      step();
      chk("s4_rd1", rd_data, mk(42));
      step();
      chk("s4_rd2", rd_data, mk(43));
      chk("s4_last", 64'(rd_last), 64'd1);
      step();
      rd_ready = 1'b0;
      chk("s4_idle", 64'(state), 64'd0);
      // 5: reset one cycle after the trigger, then a clean recapture
      capture(10, 11);
      chk("s5_post", 64'(state), 64'd2);
      smp_valid = 1'b1;
      smp_data  = mk(11);
      step();
      smp_valid = 1'b0;
      chk("s5_post2", 64'(state), 64'd2);
      reset = 1'b0;
      #1;
      chk("s5_rst_state", 64'(state), 64'd0);
      chk("s5_rst_count", 64'(count), 64'd0);
      chk("s5_rst_rd_valid", 64'(rd_valid), 64'd0);
      #2 reset = 1'b1;
      step();
      capture(10, 20);
      chk("s5_count", 64'(count), 64'd8);
      readout(5, 8, 1'b0);
      // 6: abort beats arm during ARMED; arm ignored in DONE
      capture(10, 3);
      chk("s6_armed_count", 64'(count), 64'd3);
      abort = 1'b1;
      arm   = 1'b1;
      step();
      abort = 1'b0;
      arm   = 1'b0;
      chk("s6_abort_state", 64'(state), 64'd0);
      chk("s6_abort_count", 64'(count), 64'd0);
      capture(2, 10);
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("s6_done_state", 64'(state), 64'd3);
      chk("s6_done_count", 64'(count), 64'd5);
      readout(0, 5, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
